// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared fixed-point width helpers and default widths
package fx_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_w(input int a_w, input int b_w, input int len);
        return a_w + b_w + clog2(len);
    endfunction

    // A one-sample block still needs a 1-bit counter register.
    function automatic int cnt_w(input int len);
        return (clog2(len) < 1) ? 1 : clog2(len);
    endfunction

    // Replicates bit w-1 of v into all higher bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        return 64'($signed(v << (64 - w)) >>> (64 - w));
    endfunction

    localparam int DEF_A_W   = 13;
    localparam int DEF_B_W   = 13;
    localparam int DEF_LEN   = 16;
    localparam int DEF_P_W   = DEF_A_W + DEF_B_W;
    localparam int DEF_ACC_W = DEF_P_W + clog2(DEF_LEN);

endpackage

// File: rtl/fx_block_mac_if.sv
// rtl/fx_block_mac_if.sv - sample-in / block-sum-out handshake bundle
interface fx_block_mac_if
    import fx_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic signed [A_W-1:0]   i_a;
    logic signed [B_W-1:0]   i_b;
    logic                    i_valid;
    logic                    i_ready;
    logic                    i_clear;
    logic signed [ACC_W-1:0] o_data;
    logic                    o_valid;
    logic                    o_ready;

    modport master (
        output i_a, i_b, i_valid, i_clear, o_ready,
        input  i_ready, o_data, o_valid
    );

    modport slave (
        input  i_a, i_b, i_valid, i_clear, o_ready,
        output i_ready, o_data, o_valid
    );
endinterface

// File: rtl/fx_mult_reg.sv
// rtl/fx_mult_reg.sv - registered signed multiplier with enable, valid and flush
module fx_mult_reg #(
    parameter int A_W = 13,
    parameter int B_W = 13,
    parameter int P_W = A_W + B_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p,
    output logic                  p_valid
);
    // Flush drops the valid even while stalled; the product bits are don't-care then.
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            p_valid <= 1'b0;
        end else if (clear) begin
            p_valid <= 1'b0;
        end else if (en) begin
            p_valid <= in_valid;
            if (in_valid) p <= P_W'(a) * P_W'(b);
        end
    end
endmodule

// File: rtl/fx_block_mac.sv
// rtl/fx_block_mac.sv - pipelined signed fixed-point block multiply-accumulate
module fx_block_mac
    import fx_pkg::*;
#(
    parameter int A_W    = DEF_A_W,
    parameter int B_W    = DEF_B_W,
    parameter int A_FRAC = 11,
    parameter int B_FRAC = 11,
    parameter int LEN    = DEF_LEN
) (
    input logic           clk,
    input logic           rst,
    fx_block_mac_if.slave bus
);
    localparam int P_W   = A_W + B_W;
    localparam int ACC_W = acc_w(A_W, B_W, LEN);
    localparam int CNT_W = cnt_w(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    // Output fraction is A_FRAC+B_FRAC; it is only meaningful inside the operand widths.
    if (A_FRAC > A_W || B_FRAC > B_W) begin : g_frac_check
        $error("fx_block_mac: fraction bits exceed operand width");
    end

    logic             en;
    logic             accept;
    logic             p_valid;
    logic [P_W-1:0]   p;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    assign en          = !(bus.o_valid && !bus.o_ready);
    assign bus.i_ready = en && !bus.i_clear && !rst;
    assign accept      = bus.i_valid && bus.i_ready;

    fx_mult_reg #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.i_clear),
        .en       (en),
        .in_valid (accept),
        .a        (bus.i_a),
        .b        (bus.i_b),
        .p        (p),
        .p_valid  (p_valid)
    );

    assign p_ext = ACC_W'(sext(64'(p), P_W));
    assign sum   = (cnt == '0) ? p_ext : acc + p_ext;

    // A finished block overrides the handshake drop, so back-to-back sums keep o_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            bus.o_data  <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            if (en && bus.o_valid) bus.o_valid <= 1'b0;
            if (bus.i_clear) begin
                cnt <= '0;
            end else if (en && p_valid) begin
                acc <= sum;
                if (cnt == LAST) begin
                    cnt         <= '0;
                    bus.o_data  <= sum;
                    bus.o_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fx_block_mac.sv
// tb/tb_fx_block_mac.sv - randomized and directed bench for fx_block_mac at LEN=4, 16 and 1
module tb_fx_block_mac;
    import fx_pkg::*;

    localparam int ACC4  = acc_w(13, 13, 4);
    localparam int ACC16 = DEF_ACC_W;
    localparam int ACC1  = acc_w(13, 13, 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fx_block_mac_if #(.A_W(13), .B_W(13), .ACC_W(ACC4))  if4 ();
    fx_block_mac_if #(.A_W(13), .B_W(13), .ACC_W(ACC16)) if16 ();
    fx_block_mac_if #(.A_W(13), .B_W(13), .ACC_W(ACC1))  if1 ();

    fx_block_mac #(.LEN(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    fx_block_mac #(.LEN(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
    fx_block_mac #(.LEN(1))  u1  (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int errors = 0;

    // Reference: a block sum is the plain sum of LEN accepted products.
    int     lens [3] = '{4, 16, 1};
    longint psum [3];
    int     pcnt [3];
    longint q4 [$];
    longint q16 [$];
    longint q1 [$];
    logic   acc_f [3];
    logic   ir_f [3];
    int     hs_cnt [3];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q4.size();
            1:       return q16.size();
            default: return q1.size();
        endcase
    endfunction

    task automatic qpush(input int i, input longint v);
        case (i)
            0:       q4.push_back(v);
            1:       q16.push_back(v);
            default: q1.push_back(v);
        endcase
    endtask

    task automatic qclear(input int i);
        case (i)
            0:       q4.delete();
            1:       q16.delete();
            default: q1.delete();
        endcase
    endtask

    task automatic sb_check(input int i, input longint obs);
        longint e;
        int     n;
        n = qsize(i);
        chk($sformatf("sb_len%0d_result_expected", lens[i]), (n > 0) ? 1 : 0, 1);
        if (n > 0) begin
            case (i)
                0:       e = q4.pop_front();
                1:       e = q16.pop_front();
                default: e = q1.pop_front();
            endcase
            chk($sformatf("sb_len%0d_sum", lens[i]), obs, e);
        end
    endtask

    // Samples all handshakes just after the inputs settle, then advances one clock.
    task automatic tick();
        logic   hs [3];
        logic   clr [3];
        longint pr [3];
        longint od [3];
        #1;
        acc_f[0] = if4.i_valid && if4.i_ready;   ir_f[0] = if4.i_ready;
        hs[0] = if4.o_valid && if4.o_ready;      clr[0] = if4.i_clear;
        pr[0] = longint'(if4.i_a) * longint'(if4.i_b);   od[0] = longint'(if4.o_data);
        acc_f[1] = if16.i_valid && if16.i_ready; ir_f[1] = if16.i_ready;
        hs[1] = if16.o_valid && if16.o_ready;    clr[1] = if16.i_clear;
        pr[1] = longint'(if16.i_a) * longint'(if16.i_b); od[1] = longint'(if16.o_data);
        acc_f[2] = if1.i_valid && if1.i_ready;   ir_f[2] = if1.i_ready;
        hs[2] = if1.o_valid && if1.o_ready;      clr[2] = if1.i_clear;
        pr[2] = longint'(if1.i_a) * longint'(if1.i_b);   od[2] = longint'(if1.o_data);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                psum[i] = 0;
                pcnt[i] = 0;
                qclear(i);
            end else begin
                if (hs[i]) begin
                    hs_cnt[i]++;
                    sb_check(i, od[i]);
                end
                if (clr[i]) begin
                    psum[i] = 0;
                    pcnt[i] = 0;
                end else if (acc_f[i]) begin
                    psum[i] += pr[i];
                    pcnt[i]++;
                    if (pcnt[i] == lens[i]) begin
                        qpush(i, psum[i]);
                        psum[i] = 0;
                        pcnt[i] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        if4.i_valid = 1'b0;  if4.i_clear = 1'b0;  if4.o_ready = 1'b1;  if4.i_a = '0;  if4.i_b = '0;
        if16.i_valid = 1'b0; if16.i_clear = 1'b0; if16.o_ready = 1'b1; if16.i_a = '0; if16.i_b = '0;
        if1.i_valid = 1'b0;  if1.i_clear = 1'b0;  if1.o_ready = 1'b1;  if1.i_a = '0;  if1.i_b = '0;
    endtask

    function automatic logic signed [12:0] rnd13();
        return 13'($urandom_range(0, 8191));
    endfunction

    initial begin
        logic signed [12:0] ra;
        logic signed [12:0] rb;
        longint held;
        int sent;
        int stall;
        int guard;
        int hs0;
        bit seen;

        for (int i = 0; i < 3; i++) begin
            psum[i] = 0; pcnt[i] = 0; hs_cnt[i] = 0; acc_f[i] = 1'b0; ir_f[i] = 1'b0;
        end
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        chk("rst_ovalid_len4",  if4.o_valid, 0);
        chk("rst_odata_len4",   longint'(if4.o_data), 0);
        chk("rst_iready_len4",  ir_f[0], 0);
        chk("rst_ovalid_len16", if16.o_valid, 0);
        chk("rst_iready_len16", ir_f[1], 0);
        chk("rst_ovalid_len1",  if1.o_valid, 0);
        chk("rst_odata_len1",   longint'(if1.o_data), 0);
        rst = 1'b0;
        tick();

        // LEN=4: 1..4 times 2, result two clocks after the last accept
        for (int k = 1; k <= 4; k++) begin
            if4.i_valid = 1'b1; if4.i_a = 13'(k); if4.i_b = 13'sd2;
            tick();
            chk("t1_accept", acc_f[0], 1);
        end
        if4.i_valid = 1'b0;
        chk("t1_not_early", if4.o_valid, 0);
        tick();
        chk("t1_ovalid", if4.o_valid, 1);
        chk("t1_sum", longint'(if4.o_data), 20);
        tick();
        chk("t1_ovalid_one_clk", if4.o_valid, 0);
        chk("t1_odata_holds", longint'(if4.o_data), 20);

        // LEN=16 worst-case magnitude: (-4096)*(-4096)*16 = 2^28
        for (int k = 0; k < 16; k++) begin
            if16.i_valid = 1'b1; if16.i_a = 13'h1000; if16.i_b = 13'h1000;
            tick();
        end
        if16.i_valid = 1'b0;
        tick();
        chk("t2_ovalid", if16.o_valid, 1);
        chk("t2_sum_2p28", longint'(if16.o_data), 268435456);
        tick();

        // Two random LEN=4 blocks with a 5-clock output stall after the first result
        sent = 0; stall = 0; guard = 0; seen = 1'b0; held = 0;
        hs0 = hs_cnt[0];
        ra = rnd13(); rb = rnd13();
        while (sent < 8 && guard < 200) begin
            guard++;
            if4.i_valid = 1'b1; if4.i_a = ra; if4.i_b = rb;
            if (!seen && if4.o_valid) begin
                seen = 1'b1;
                stall = 5;
                held = longint'(if4.o_data);
            end
            if4.o_ready = (stall == 0);
            tick();
            if (stall > 0) begin
                chk("t3_iready_low_in_stall", ir_f[0], 0);
                chk("t3_odata_stable", longint'(if4.o_data), held);
                chk("t3_ovalid_held", if4.o_valid, 1);
                stall--;
            end
            if (acc_f[0]) begin
                sent++;
                ra = rnd13(); rb = rnd13();
            end
        end
        chk("t3_all_sent", sent, 8);
        chk("t3_stall_seen", seen, 1);
        idle_all();
        for (int k = 0; k < 4; k++) tick();
        chk("t3_two_results", hs_cnt[0] - hs0, 2);

        // LEN=4 flush: 2 x (5*5), clear (with a competing sample), then 4 x (1*1)
        for (int k = 0; k < 2; k++) begin
            if4.i_valid = 1'b1; if4.i_a = 13'sd5; if4.i_b = 13'sd5;
            tick();
        end
        if4.i_valid = 1'b0;
        tick();
        if4.i_clear = 1'b1; if4.i_valid = 1'b1; if4.i_a = 13'sd7; if4.i_b = 13'sd7;
        tick();
        chk("t4_clear_blocks_ready", ir_f[0], 0);
        chk("t4_clear_no_accept", acc_f[0], 0);
        if4.i_clear = 1'b0;
        hs0 = hs_cnt[0];
        for (int k = 0; k < 4; k++) begin
            if4.i_valid = 1'b1; if4.i_a = 13'sd1; if4.i_b = 13'sd1;
            tick();
        end
        if4.i_valid = 1'b0;
        tick();
        chk("t4_ovalid", if4.o_valid, 1);
        chk("t4_sum", longint'(if4.o_data), 4);
        tick();
        tick();
        chk("t4_single_result", hs_cnt[0] - hs0, 1);

        // LEN=1 back-to-back, then with o_ready toggling
        for (int k = 1; k <= 3; k++) begin
            if1.i_valid = 1'b1; if1.i_a = 13'(k); if1.i_b = 13'sd3;
            tick();
            if (k == 1) chk("t5_first_latency", if1.o_valid, 0);
            if (k > 1) begin
                chk("t5_ovalid_run", if1.o_valid, 1);
                chk("t5_seq", longint'(if1.o_data), 3 * (k - 1));
            end
        end
        if1.i_valid = 1'b0;
        tick();
        chk("t5_ovalid_run", if1.o_valid, 1);
        chk("t5_seq", longint'(if1.o_data), 9);
        tick();
        chk("t5_ovalid_end", if1.o_valid, 0);
        hs0 = hs_cnt[2];
        sent = 0; guard = 0;
        while (sent < 3 && guard < 50) begin
            guard++;
            if1.i_valid = 1'b1; if1.i_a = 13'(sent + 1); if1.i_b = 13'sd3;
            if1.o_ready = guard[0];
            tick();
            if (acc_f[2]) sent++;
        end
        if1.i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if1.o_ready = k[0];
            tick();
        end
        if1.o_ready = 1'b1;
        tick();
        tick();
        chk("t5_toggle_sent", sent, 3);
        chk("t5_toggle_results", hs_cnt[2] - hs0, 3);

        // Reset mid-block on LEN=4, then a clean 4 x (2*2) block
        for (int k = 0; k < 3; k++) begin
            if4.i_valid = 1'b1; if4.i_a = 13'sd9; if4.i_b = 13'sd9;
            tick();
        end
        if4.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_ovalid_in_rst", if4.o_valid, 0);
        chk("t6_iready_in_rst", ir_f[0], 0);
        rst = 1'b0;
        tick();
        chk("t6_ovalid_after_rst", if4.o_valid, 0);
        for (int k = 0; k < 4; k++) begin
            if4.i_valid = 1'b1; if4.i_a = 13'sd2; if4.i_b = 13'sd2;
            tick();
        end
        if4.i_valid = 1'b0;
        tick();
        chk("t6_ovalid", if4.o_valid, 1);
        chk("t6_sum", longint'(if4.o_data), 16);
        tick();

        // Random traffic with random backpressure on LEN=4 and LEN=16
        for (int c = 0; c < 400; c++) begin
            if4.i_valid  = ($urandom_range(0, 9) < 7);
            if4.o_ready  = ($urandom_range(0, 9) < 7);
            if4.i_a      = rnd13(); if4.i_b = rnd13();
            if16.i_valid = ($urandom_range(0, 9) < 8);
            if16.o_ready = ($urandom_range(0, 9) < 6);
            if16.i_a     = rnd13(); if16.i_b = rnd13();
            tick();
        end
        idle_all();
        for (int k = 0; k < 6; k++) tick();
        chk("end_len4_all_delivered",  qsize(0), 0);
        chk("end_len16_all_delivered", qsize(1), 0);
        chk("end_len1_all_delivered",  qsize(2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
